// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet FCS inserter.
//   - state_e   : sequencer state encoding (3 bits)
//   - FCS_BYTES, FLUSH_CYCLES, PRESET_BYTES, MIN_FRAME_DEF : framing constants
//   - CRC_POLY  : CRC-32 generator polynomial (normal, non-reflected form)
//   - bitrev8 / bitrev32 : bit-order reversal helpers
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_PAD   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FCS   = 3'd4
  } state_e;

  localparam int FCS_BYTES     = 4;
  localparam int FLUSH_CYCLES  = 4;
  localparam int PRESET_BYTES  = 4;
  localparam int MIN_FRAME_DEF = 60;

  localparam int                CNT_W   = 6;
  localparam logic [CNT_W-1:0]  CNT_MAX = 6'd63;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_fcs_inserter_crc32.sv
// CRC-32 engine, shift-in (polynomial division) form with zero preset.
// Each write shifts rx_byte in MSB first; the caller supplies the 32
// augmentation zero bits itself to obtain the final remainder.
// Ports:
//   clk     : clock
//   reset   : synchronous clear; when asserted together with rx_we the
//             byte is shifted into a zero register (starts a new message)
//   rx_we   : shift rx_byte into the remainder this cycle
//   rx_byte : byte to shift in, bit 7 first
//   tx_crc  : remainder including the byte presented this cycle
module crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_we,
  input  logic [7:0]  rx_byte,
  output logic [31:0] tx_crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = reset ? 32'd0 : crc_q;
    if (rx_we) begin
      for (int i = 7; i >= 0; i--) begin
        crc_d = {crc_d[30:0], rx_byte[i]} ^ (crc_d[31] ? CRC_POLY : 32'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_we || reset) crc_q <= crc_d;
  end

  // Look-ahead view: lets the caller register the final remainder in the
  // same cycle the last augmentation byte is shifted in.
  assign tx_crc = crc_d;

endmodule

// File: rtl/eth_fcs_inserter.sv
// Ethernet FCS inserter: passes MAC TX bytes straight through to the PHY
// side, steers the crc32 engine so its remainder becomes the IEEE 802.3
// FCS, then appends the four FCS bytes (LSB byte first).
// Optional zero padding to MIN_FRAME bytes is compiled in with the macro
// ETH_FCS_PAD_EN; without it short frames go straight to the FCS.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready : upstream byte stream
//   m_data/m_valid/m_last/m_ready : downstream byte stream, m_last on the
//                                   final FCS byte
//   frame_done          : pulse on the transfer of the final FCS byte
module eth_fcs_inserter
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = MIN_FRAME_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_done
);

  // The byte counter saturates at CNT_MAX, so padding can only terminate
  // for targets it can reach.
  if (MIN_FRAME < 1 || MIN_FRAME > 63) begin : g_bad_min_frame
    $error("eth_fcs_inserter: MIN_FRAME must be within 1..63");
  end

  localparam logic [CNT_W-1:0] PRESET_C    = CNT_W'(PRESET_BYTES);
  localparam logic [1:0]       FLUSH_LAST  = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0]       FCS_LAST    = 2'(FCS_BYTES - 1);
`ifdef ETH_FCS_PAD_EN
  localparam logic [31:0]      MIN_U       = 32'(MIN_FRAME);
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  // Complementing the first 32 message bits emulates an all-ones preset on
  // a zero-preset engine.
  function automatic logic [7:0] preset_mask(input logic [CNT_W-1:0] cnt);
    return (cnt < PRESET_C) ? 8'hFF : 8'h00;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        flush_q, flush_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       fcs_q, fcs_d;

  logic              crc_clr;
  logic              crc_we;
  logic [7:0]        crc_byte;
  logic [31:0]       crc_val;

  logic              s_ready_c, m_valid_c, m_last_c, done_c;
  logic [7:0]        m_data_c;

  crc32 u_crc32 (
    .clk     (clk),
    .reset   (crc_clr),
    .rx_we   (crc_we),
    .rx_byte (crc_byte),
    .tx_crc  (crc_val)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    idx_d     = idx_q;
    fcs_d     = fcs_q;
    crc_clr   = 1'b0;
    crc_we    = 1'b0;
    crc_byte  = 8'h00;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    m_data_c  = 8'h00;
    m_last_c  = 1'b0;
    done_c    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DATA: begin
        s_ready_c = m_ready;
        m_valid_c = s_valid;
        m_data_c  = s_data;
        if (s_valid && m_ready) begin
          crc_we   = 1'b1;
          crc_byte = bitrev8(s_data) ^ preset_mask(cnt_q);
          // First byte of a frame restarts the engine from zero.
          crc_clr  = (state_q == ST_IDLE);
          cnt_d    = sat_inc(cnt_q);
          if (s_last) begin
            flush_d = 2'd0;
`ifdef ETH_FCS_PAD_EN
            if ({{(32-CNT_W){1'b0}}, cnt_q} + 32'd1 < MIN_U) state_d = ST_PAD;
            else                                             state_d = ST_FLUSH;
`else
            state_d = ST_FLUSH;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end

`ifdef ETH_FCS_PAD_EN
      ST_PAD: begin
        m_valid_c = 1'b1;
        if (m_ready) begin
          crc_we   = 1'b1;
          crc_byte = preset_mask(cnt_q);
          cnt_d    = sat_inc(cnt_q);
          if ({{(32-CNT_W){1'b0}}, cnt_q} + 32'd1 >= MIN_U) begin
            state_d = ST_FLUSH;
            flush_d = 2'd0;
          end
        end
      end
`endif

      ST_FLUSH: begin
        // 32 augmentation zero bits complete the polynomial division.
        crc_we  = 1'b1;
        flush_d = flush_q + 2'd1;
        if (flush_q == FLUSH_LAST) begin
          state_d = ST_FCS;
          idx_d   = 2'd0;
          fcs_d   = ~bitrev32(crc_val);
        end
      end

      ST_FCS: begin
        m_valid_c = 1'b1;
        m_data_c  = fcs_q[{idx_q, 3'b000} +: 8];
        m_last_c  = (idx_q == FCS_LAST);
        if (m_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == FCS_LAST) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow reset immediately, not at the next edge.
    if (reset) begin
      s_ready_c = 1'b0;
      m_valid_c = 1'b0;
      m_data_c  = 8'h00;
      m_last_c  = 1'b0;
      done_c    = 1'b0;
      crc_we    = 1'b0;
      crc_clr   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= 2'd0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    fcs_q <= fcs_d;
  end

  assign s_ready    = s_ready_c;
  assign m_valid    = m_valid_c;
  assign m_data     = m_data_c;
  assign m_last     = m_last_c;
  assign frame_done = done_c;

endmodule

// File: doc/eth_fcs_inserter.md
Name: eth_fcs_inserter

Overview:
- Byte-stream sequencer for the existing crc32 engine (poly 0x04C11DB7, shift-in form, zero preset).
- Sits between the MAC TX byte source and the PHY-side serializer.
- Passes frame bytes through unchanged, drives crc32 so the result equals the IEEE 802.3 FCS, then appends the 4 FCS bytes.
- Marks the last FCS byte as end of frame.

Parameters:
- MIN_FRAME, 60, minimum payload length in bytes (before FCS) used when padding is compiled in.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_data  in  8  input frame byte
- s_valid  in  1  input byte valid
- s_last  in  1  input byte is last of frame
- s_ready  out  1  input accepted when s_valid & s_ready
- m_data  out  8  output byte
- m_valid  out  1  output byte valid
- m_last  out  1  output byte is last FCS byte
- m_ready  in  1  downstream ready
- frame_done  out  1  one-cycle pulse when last FCS byte transfers

Behaviour:
- Reset: state=IDLE, byte count=0, frame_done=0, s_ready=0, m_valid=0, m_last=0, m_data=0.
- Reset is asynchronous and active-high. The crc32 instance is cleared through its own reset input, as described below.
- States and transitions:
  - IDLE: no frame in progress. First accepted byte → DATA, or straight to FLUSH if s_last=1.
  - DATA: subsequent frame bytes.
  - PAD: compile-option only, zero-byte padding.
  - FLUSH: exactly 4 cycles, unconditional.
  - FCS: 4 output transfers, then → IDLE.
- IDLE/DATA pass-through, zero latency, combinational:
  - s_ready=m_ready; m_valid=s_valid; m_data=s_data; m_last=0.
- CRC feed:
  - crc32.rx_we=1 on every accepted byte.
  - rx_byte = bitrev8(s_data) XOR (count<4 ? 8'hFF : 8'h00). Complementing the first 32 bits emulates the all-ones preset.
  - crc32.reset driven high in the same cycle the first byte (IDLE) is accepted, so the frame starts from zero.
- Byte count: increments per accepted byte, saturates at 63, and clears on return to IDLE.
- Accepting s_last: → PAD if the option is enabled and count+1<MIN_FRAME, else → FLUSH.
- FLUSH: s_ready=0, m_valid=0; crc32 fed 8'h00 with rx_we=1 each cycle (32 augmentation zero bits).
- FCS:
  - Registered fcs = ~bitrev32(crc32.tx_crc), captured at FLUSH exit.
  - Sends fcs[7:0], [15:8], [23:16], [31:24] in that order. Each byte holds until m_ready; m_data/m_valid stay stable while stalled.
  - m_last=1 on the 4th byte. frame_done pulses on its transfer.
  - s_ready=0 throughout FCS.
- Frames shorter than 4 bytes without padding:
  - The complement applies only to the bytes present.
  - The appended FCS is the engine result, not 802.3-compliant; no error is flagged.
- s_last with s_valid=0 is ignored.
- Reset mid-frame: immediate return to IDLE. The partial frame is dropped with no FCS; the next accepted byte starts a fresh CRC.
- Throughput: N-byte frame with m_ready=1 takes N+8 cycles. The next frame's first byte may be accepted the cycle after the last FCS transfer.

Optional Feature:
- Macro ETH_FCS_PAD_EN.
- Defined:
  - A frame ending with count<MIN_FRAME enters PAD.
  - PAD emits 8'h00 bytes (m_valid=1, s_ready=0), each fed to crc32 like data, including the first-4 complement rule.
  - Leaves PAD when count reaches MIN_FRAME, then → FLUSH.
- Undefined: PAD state absent; short frames go directly to FLUSH.

Decomposition:
- Shared package/header eth_pkg:
  - State encoding (IDLE, DATA, PAD, FLUSH, FCS; 3-bit)
  - FCS_BYTES=4
  - FLUSH_CYCLES=4
  - PRESET_BYTES=4
  - Default MIN_FRAME=60
- Sub-module: the existing crc32 instance only; no new sub-module.
- bitrev8/bitrev32 are package functions.

Test Plan:
- Frame ASCII "123456789" (31 32 33 34 35 36 37 38 39), m_ready=1 → output the 9 bytes, then 26 39 F4 CB. m_last and frame_done on CB. 17 cycles total.
- Same frame with m_ready toggling 1/0 every cycle → identical byte sequence; m_data stable during stalls; no byte duplicated or lost.
- Back-to-back: two "123456789" frames with s_valid held high → both end in 26 39 F4 CB. s_ready=0 during FLUSH/FCS; the second frame's first byte is accepted the cycle after the first CB.
- Reset asserted after 5 bytes of a frame → outputs return to reset values asynchronously. A following "123456789" frame yields 26 39 F4 CB.
- With ETH_FCS_PAD_EN, 1-byte frame 8'h31 → 8'h31 followed by 59 zero bytes, then an FCS matching a software CRC-32 of the 60-byte buffer. Without the macro → 8'h31 plus 4 FCS bytes, total 5 bytes.
- 64-byte frame of 8'hFF → 64 pass-through bytes, then an FCS equal to the software zlib crc32 of that buffer, LSB byte first.
